mems_dac_spi: RTL and testbench

MEMS_DAC_SPI -- requirements
Module: mems_dac_spi

---
 rtl/mems_dac_spi_if.sv | 36 +++
 rtl/mems_dac_spi.sv | 179 +++++++++++++++++
 tb/tb_mems_dac_spi.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mems_dac_spi_if.sv
// Sequencer, pattern-ROM and DAC pins of mems_dac_spi, grouped for port connection.
// The dac_ldac_n pin exists only when MEMS_SPI_LDAC_EN is defined.
interface mems_dac_spi_if ();
    logic        start;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_sync_n;
`ifdef MEMS_SPI_LDAC_EN
    logic        dac_ldac_n;

    modport slave (
        input  start, addr, rom_data,
        output busy, done, rom_addr, dac_sclk, dac_mosi, dac_sync_n, dac_ldac_n
    );

    modport master (
        output start, addr, rom_data,
        input  busy, done, rom_addr, dac_sclk, dac_mosi, dac_sync_n, dac_ldac_n
    );
`else
    modport slave (
        input  start, addr, rom_data,
        output busy, done, rom_addr, dac_sclk, dac_mosi, dac_sync_n
    );

    modport master (
        output start, addr, rom_data,
        input  busy, done, rom_addr, dac_sclk, dac_mosi, dac_sync_n
    );
`endif
endinterface

// File: rtl/mems_dac_spi.sv
// Fetches one 24-bit word from a synchronous pattern ROM and shifts it MSB-first to a SPI DAC.
// Define MEMS_SPI_LDAC_EN to add an LDAC strobe state and the dac_ldac_n pin after each frame.
module mems_dac_spi #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mems_dac_spi_if.slave bus
);

    localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LastFall = 5'd24;

`ifdef MEMS_SPI_LDAC_EN
    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StGap, StLdac} state_e;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StGap} state_e;
`endif

    state_e      r_state;
    state_e      w_state_nxt;

    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic [15:0] r_rom_addr, w_rom_addr_nxt;
    logic        r_sclk,     w_sclk_nxt;
    logic        r_mosi,     w_mosi_nxt;
    logic        r_sync_n,   w_sync_n_nxt;
    logic [23:0] r_shift,    w_shift_nxt;
    logic [4:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0]  r_div_cnt,  w_div_cnt_nxt;
`ifdef MEMS_SPI_LDAC_EN
    logic        r_ldac_n,   w_ldac_n_nxt;
`endif

    logic        w_div_end;
    logic        w_shift_exit;

    assign w_div_end = (r_div_cnt == DivLast);
    // Frame ends at the close of the low half-period after the 24th falling edge.
    assign w_shift_exit = w_div_end && !r_sclk && (r_bit_cnt == LastFall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (bus.start) w_state_nxt = StFetch;
            StFetch: w_state_nxt = StLoad;
            StLoad:  w_state_nxt = StShift;
            StShift: if (w_shift_exit) w_state_nxt = StGap;
`ifdef MEMS_SPI_LDAC_EN
            StGap:   if (w_div_end) w_state_nxt = StLdac;
            StLdac:  if (w_div_end) w_state_nxt = StIdle;
`else
            StGap:   if (w_div_end) w_state_nxt = StIdle;
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_rom_addr_nxt = r_rom_addr;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_sync_n_nxt   = r_sync_n;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_div_cnt_nxt  = r_div_cnt;
`ifdef MEMS_SPI_LDAC_EN
        w_ldac_n_nxt   = 1'b1;
`endif
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_rom_addr_nxt = bus.addr;
                    w_busy_nxt     = 1'b1;
                end
            end
            StLoad: begin
                w_shift_nxt   = bus.rom_data;
                w_mosi_nxt    = bus.rom_data[23];
                w_sclk_nxt    = 1'b1;
                w_sync_n_nxt  = 1'b0;
                w_bit_cnt_nxt = '0;
                w_div_cnt_nxt = '0;
            end
            StShift: begin
                w_div_cnt_nxt = w_div_end ? 8'd0 : r_div_cnt + 8'd1;
                if (w_div_end) begin
                    if (r_sclk) begin
                        w_sclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end else if (r_bit_cnt == LastFall) begin
                        w_sclk_nxt   = 1'b1;
                        w_sync_n_nxt = 1'b1;
                    end else begin
                        // Next bit goes out with the rising edge, stable across the falling one.
                        w_sclk_nxt  = 1'b1;
                        w_shift_nxt = {r_shift[22:0], 1'b0};
                        w_mosi_nxt  = r_shift[22];
                    end
                end
            end
            StGap: begin
                w_div_cnt_nxt = w_div_end ? 8'd0 : r_div_cnt + 8'd1;
                if (w_div_end) begin
`ifdef MEMS_SPI_LDAC_EN
                    w_ldac_n_nxt = 1'b0;
`else
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
`endif
                end
            end
`ifdef MEMS_SPI_LDAC_EN
            StLdac: begin
                w_div_cnt_nxt = w_div_end ? 8'd0 : r_div_cnt + 8'd1;
                if (w_div_end) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_ldac_n_nxt = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rom_addr <= '0;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_sync_n   <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
`ifdef MEMS_SPI_LDAC_EN
            r_ldac_n   <= 1'b1;
`endif
        end else begin
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_sync_n   <= w_sync_n_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
`ifdef MEMS_SPI_LDAC_EN
            r_ldac_n   <= w_ldac_n_nxt;
`endif
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.dac_sclk   = r_sclk;
    assign bus.dac_mosi   = r_mosi;
    assign bus.dac_sync_n = r_sync_n;
`ifdef MEMS_SPI_LDAC_EN
    assign bus.dac_ldac_n = r_ldac_n;
`endif

endmodule

// File: tb/tb_mems_dac_spi.sv
// Directed bench for mems_dac_spi: three instances (CLK_DIV 4, 1, 255) sharing one pattern ROM,
// each with a DAC-side decoder that captures mosi on sclk falling edges while sync_n is low.
module tb_mems_dac_spi;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_vec = 3'b000;
    logic [15:0] addr = 16'h0000;
    logic [2:0]  done_vec;
    logic [2:0]  busy_vec;
    logic [23:0] rom [512];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MEMS_SPI_LDAC_EN
    localparam int LdacExtra = 1;
`else
    localparam int LdacExtra = 0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mems_dac_spi_if u_bus ();

        mems_dac_spi #(
            .CLK_DIV((g == 0) ? 4 : ((g == 1) ? 1 : 255))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_bus.slave)
        );

        assign u_bus.start = start_vec[g];
        assign u_bus.addr  = addr;
        assign done_vec[g] = u_bus.done;
        assign busy_vec[g] = u_bus.busy;

        always @(posedge clk) u_bus.rom_data <= rom[u_bus.rom_addr[8:0]];

        logic [23:0] mon_shift  = '0;
        logic [23:0] last_frame = '0;
        int frame_falls = 0;
        int last_falls  = 0;
        int frames      = 0;
        int busy_run    = 0;
        int last_busy   = 0;
        int done_cnt    = 0;
        int hi_run      = 0;
        int last_hi     = 0;
        int ldac_run    = 0;
        int last_ldac   = 0;

        always @(negedge u_bus.dac_sclk) begin
            if (u_bus.dac_sync_n === 1'b0) begin
                mon_shift = {mon_shift[22:0], u_bus.dac_mosi};
                frame_falls++;
            end
        end

        always @(negedge u_bus.dac_sync_n) begin
            mon_shift   = '0;
            frame_falls = 0;
        end

        always @(posedge u_bus.dac_sync_n) begin
            last_frame = mon_shift;
            last_falls = frame_falls;
            frames++;
        end

        always @(negedge clk) begin
            if (u_bus.busy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
            if (u_bus.done === 1'b1) done_cnt++;
            if (u_bus.dac_sync_n === 1'b1) hi_run++;
            else begin
                if (hi_run > 0) last_hi = hi_run;
                hi_run = 0;
            end
`ifdef MEMS_SPI_LDAC_EN
            if (u_bus.dac_ldac_n === 1'b0) ldac_run++;
            else if (ldac_run > 0) begin
                last_ldac = ldac_run;
                ldac_run  = 0;
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int g, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (done_vec[g] === 1'b1) ok = 1'b1;
        end
    endtask

    function automatic int exp_busy(input int d);
        return 2 + (49 + LdacExtra) * d;
    endfunction

    initial begin
        bit ok;
        int base;
        for (int i = 0; i < 512; i++) rom[i] = 24'h000000;
        rom[9'h008] = 24'h3F8001;
        rom[9'h009] = 24'h5A0C3E;
        rom[9'h020] = 24'hAAAAAA;
        rom[9'h100] = 24'h123456;

        // Reset values
        step(3);
        chk("rst_busy",   32'(g_dut[0].u_bus.busy), 32'd0);
        chk("rst_done",   32'(g_dut[0].u_bus.done), 32'd0);
        chk("rst_romadr", 32'(g_dut[0].u_bus.rom_addr), 32'd0);
        chk("rst_sclk",   32'(g_dut[0].u_bus.dac_sclk), 32'd1);
        chk("rst_mosi",   32'(g_dut[0].u_bus.dac_mosi), 32'd0);
        chk("rst_sync",   32'(g_dut[0].u_bus.dac_sync_n), 32'd1);
`ifdef MEMS_SPI_LDAC_EN
        chk("rst_ldac",   32'(g_dut[0].u_bus.dac_ldac_n), 32'd1);
`endif
        rst_n = 1'b1;
        step(2);

        // Single transfer, CLK_DIV=4
        base = g_dut[0].done_cnt;
        addr = 16'h0008;
        start_vec = 3'b001;
        step(1);
        start_vec = 3'b000;
        chk("t1_busy_on", 32'(busy_vec[0]), 32'd1);
        chk("t1_romadr",  32'(g_dut[0].u_bus.rom_addr), 32'h0008);
        wait_done(0, 400, ok);
        chk("t1_done_seen", 32'(ok), 32'd1);
        chk("t1_busy_off",  32'(busy_vec[0]), 32'd0);
        step(1);
        chk("t1_frame", 32'(g_dut[0].last_frame), 32'h3F8001);
        chk("t1_falls", 32'(g_dut[0].last_falls), 32'd24);
        chk("t1_busy_len", 32'(g_dut[0].last_busy), 32'(exp_busy(4)));
        chk("t1_done_once", 32'(g_dut[0].done_cnt - base), 32'd1);
`ifdef MEMS_SPI_LDAC_EN
        chk("t1_ldac_len", 32'(g_dut[0].last_ldac), 32'd4);
`endif

        // Start re-pulsed mid-transfer must be ignored
        base = g_dut[0].frames;
        addr = 16'h0008;
        start_vec = 3'b001;
        step(1);
        start_vec = 3'b000;
        step(49);
        addr = 16'h0100;
        start_vec = 3'b001;
        step(1);
        start_vec = 3'b000;
        chk("t2_romadr_mid", 32'(g_dut[0].u_bus.rom_addr), 32'h0008);
        wait_done(0, 400, ok);
        chk("t2_done_seen", 32'(ok), 32'd1);
        step(20);
        chk("t2_frames",  32'(g_dut[0].frames - base), 32'd1);
        chk("t2_idle",    32'(busy_vec[0]), 32'd0);
        chk("t2_romadr",  32'(g_dut[0].u_bus.rom_addr), 32'h0008);
        chk("t2_frame",   32'(g_dut[0].last_frame), 32'h3F8001);

        // Back-to-back with start held high
        base = g_dut[0].frames;
        addr = 16'h0008;
        start_vec = 3'b001;
        step(1);
        addr = 16'h0009;
        wait_done(0, 400, ok);
        chk("t3_done1_seen", 32'(ok), 32'd1);
        chk("t3_frame1", 32'(g_dut[0].last_frame), 32'h3F8001);
        step(1);
        chk("t3_accept_busy", 32'(busy_vec[0]), 32'd1);
        chk("t3_accept_adr",  32'(g_dut[0].u_bus.rom_addr), 32'h0009);
        start_vec = 3'b000;
        wait_done(0, 400, ok);
        chk("t3_done2_seen", 32'(ok), 32'd1);
        step(1);
        chk("t3_frame2", 32'(g_dut[0].last_frame), 32'h5A0C3E);
        chk("t3_frames", 32'(g_dut[0].frames - base), 32'd2);
        chk("t3_gap_ge4", 32'(g_dut[0].last_hi >= 4), 32'd1);

        // Reset at bit 10
        addr = 16'h0008;
        start_vec = 3'b001;
        step(1);
        start_vec = 3'b000;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step(1);
            if (g_dut[0].frame_falls == 10) ok = 1'b1;
        end
        chk("t4_bit10_seen", 32'(ok), 32'd1);
        base = g_dut[0].done_cnt;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t4_sync", 32'(g_dut[0].u_bus.dac_sync_n), 32'd1);
        chk("t4_sclk", 32'(g_dut[0].u_bus.dac_sclk), 32'd1);
        chk("t4_busy", 32'(busy_vec[0]), 32'd0);
        chk("t4_done", 32'(done_vec[0]), 32'd0);
        step(2);
        addr = 16'h0009;
        start_vec = 3'b001;
        step(1);
        start_vec = 3'b000;
        wait_done(0, 400, ok);
        chk("t4_done_seen", 32'(ok), 32'd1);
        step(1);
        chk("t4_frame", 32'(g_dut[0].last_frame), 32'h5A0C3E);
        chk("t4_falls", 32'(g_dut[0].last_falls), 32'd24);
        chk("t4_busy_len", 32'(g_dut[0].last_busy), 32'(exp_busy(4)));
        chk("t4_no_rst_done", 32'(g_dut[0].done_cnt - base), 32'd1);

        // Divider extremes
        addr = 16'h0020;
        start_vec = 3'b010;
        step(1);
        start_vec = 3'b000;
        wait_done(1, 200, ok);
        chk("d1_done_seen", 32'(ok), 32'd1);
        step(1);
        chk("d1_frame", 32'(g_dut[1].last_frame), 32'hAAAAAA);
        chk("d1_falls", 32'(g_dut[1].last_falls), 32'd24);
        chk("d1_busy_len", 32'(g_dut[1].last_busy), 32'(exp_busy(1)));

        start_vec = 3'b100;
        step(1);
        start_vec = 3'b000;
        wait_done(2, 14000, ok);
        chk("d255_done_seen", 32'(ok), 32'd1);
        step(1);
        chk("d255_frame", 32'(g_dut[2].last_frame), 32'hAAAAAA);
        chk("d255_falls", 32'(g_dut[2].last_falls), 32'd24);
        chk("d255_busy_len", 32'(g_dut[2].last_busy), 32'(exp_busy(255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
